rv_key_ctrl: RTL and testbench

RV_KEY_CTRL -- requirements
Module: rv_key_ctrl

---
 rtl/rv_key_ctrl.sv | 150 +++++++++++++++
 tb/tb_rv_key_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rv_key_ctrl.sv
// rv_key_ctrl -- debounced push-button peripheral with a press-capture
// interrupt.
//
// Register map (word index = data_addr_i[3:2]):
//   0x0 STATE  RO   debounced keys, active-high
//   0x4 EDGE   W1C  press-capture flags
//   0x8 IRQ_EN RW   per-key interrupt enable
//   0xC        --   reserved: reads 0, writes ignored
//
// Ports:
//   clk_i, arst_ni       clock and asynchronous active-low reset
//   key_ni[NUM_KEYS]     raw board keys, active-low, asynchronous
//   data_req_i/we_i/be_i/addr_i/wdata_i   bus request from the MMU
//   data_rvalid_o/rdata_o                 registered response, one cycle later
//   irq_o                registered OR of (EDGE & IRQ_EN)

package rv_pkg;
    parameter int          XLEN        = 32;
    parameter logic [31:0] ADDRESS_KEY = 32'h1000_7000;
endpackage

// Per-key synchronizer and debouncer.
module rv_key_deb #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic key_ni,
    output logic stable_o,
    output logic press_o
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_synced;
    logic          w_accept;

    assign w_synced = r_sync[1];
    assign w_accept = (w_synced != r_stable) && (r_cnt == CNT_MAX);
    assign stable_o = r_stable;
    // Press is flagged on the same edge the stable value rises.
    assign press_o  = w_accept && w_synced;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_sync   <= '0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            // The inversion sits in front of the flops so that the reset
            // value 0 means "released"; otherwise a released key would look
            // pressed for two cycles after reset.
            r_sync <= {r_sync[0], ~key_ni};
            if (w_synced == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= w_synced;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

module rv_key_ctrl #(
    parameter int             XLEN            = rv_pkg::XLEN,
    parameter int             NUM_KEYS        = 4,
    parameter int             DEBOUNCE_CYCLES = 50000,
    parameter logic [XLEN-1:0] BASE_ADDR      = XLEN'(rv_pkg::ADDRESS_KEY)
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic [NUM_KEYS-1:0] key_ni,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [XLEN/8-1:0]   data_be_i,
    input  logic [XLEN-1:0]     data_addr_i,
    input  logic [XLEN-1:0]     data_wdata_i,
    output logic                data_rvalid_o,
    output logic [XLEN-1:0]     data_rdata_o,
    output logic                irq_o
);
    logic [NUM_KEYS-1:0] w_stable;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_clr;
    logic [NUM_KEYS-1:0] r_edge;
    logic [NUM_KEYS-1:0] r_irq_en;
    logic [XLEN-1:0]     w_rd;
    logic [XLEN-1:0]     r_rdata;
    logic                r_rvalid;
    logic                r_irq;
    logic                w_sel;
    logic                w_wr;
    logic [1:0]          w_idx;
    logic                w_unused;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        rv_key_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk_i   (clk_i),
            .arst_ni (arst_ni),
            .key_ni  (key_ni[k]),
            .stable_o(w_stable[k]),
            .press_o (w_press[k])
        );
    end

    assign w_sel = data_req_i && (data_addr_i[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
    assign w_idx = data_addr_i[3:2];
    // Only byte lane 0 carries register bits; without it a write is a no-op.
    assign w_wr  = w_sel && data_we_i && data_be_i[0];
    assign w_clr = (w_wr && w_idx == 2'd1) ? data_wdata_i[NUM_KEYS-1:0] : '0;

    always_comb begin
        w_rd = '0;
        case (w_idx)
            2'd0:    w_rd[NUM_KEYS-1:0] = w_stable;
            2'd1:    w_rd[NUM_KEYS-1:0] = r_edge;
            2'd2:    w_rd[NUM_KEYS-1:0] = r_irq_en;
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_edge   <= '0;
            r_irq_en <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
        end else begin
            // A press on the same edge as its W1C wins.
            r_edge   <= (r_edge & ~w_clr) | w_press;
            if (w_wr && w_idx == 2'd2)
                r_irq_en <= data_wdata_i[NUM_KEYS-1:0];
            r_rvalid <= w_sel;
            r_rdata  <= (w_sel && !data_we_i) ? w_rd : '0;
            r_irq    <= |(r_edge & r_irq_en);
        end
    end

    assign data_rvalid_o = r_rvalid;
    assign data_rdata_o  = r_rdata;
    assign irq_o         = r_irq;

    assign w_unused = ^{data_addr_i[1:0], data_be_i, data_wdata_i};
endmodule

// File: tb/tb_rv_key_ctrl.sv
module tb_rv_key_ctrl;
    localparam int          XLEN = 32;
    localparam int          NK   = 4;
    localparam logic [31:0] BASE = 32'h1000_7000;
    localparam logic [31:0] A_STATE = BASE + 32'h0;
    localparam logic [31:0] A_EDGE  = BASE + 32'h4;
    localparam logic [31:0] A_IEN   = BASE + 32'h8;
    localparam logic [31:0] A_RSV   = BASE + 32'hC;

    logic            clk = 1'b0;
    logic            arst_n;
    logic [NK-1:0]   key_n;
    logic            req, we;
    logic [3:0]      be;
    logic [31:0]     addr, wdata;
    logic            rvalid, irq;
    logic [31:0]     rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_key_ctrl #(
        .XLEN(XLEN), .NUM_KEYS(NK), .DEBOUNCE_CYCLES(4), .BASE_ADDR(BASE)
    ) dut (
        .clk_i        (clk),
        .arst_ni      (arst_n),
        .key_ni       (key_n),
        .data_req_i   (req),
        .data_we_i    (we),
        .data_be_i    (be),
        .data_addr_i  (addr),
        .data_wdata_i (wdata),
        .data_rvalid_o(rvalid),
        .data_rdata_o (rdata),
        .irq_o        (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle bus access; returns the response seen right after the edge.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic rv);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        tick(1);
        rv = rvalid; rd = rdata;
        req = 1'b0; we = 1'b0; wdata = '0; be = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d; logic v;
        bus(1'b0, a, 32'h0, 4'hF, d, v);
        chk({tag, " rvalid"}, {31'b0, v}, 32'd1);
        chk(tag, d, exp);
    endtask

    task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b);
        logic [31:0] r; logic v;
        bus(1'b1, a, d, b, r, v);
        chk({tag, " rvalid"}, {31'b0, v}, 32'd1);
        chk({tag, " rdata"}, r, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        arst_n = 1'b0; key_n = '1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        #12;
        chk("rst rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst irq", {31'b0, irq}, 32'd0);
        #2 arst_n = 1'b1;
        tick(3);
        rd_chk("rst STATE", A_STATE, 32'h0);
        rd_chk("rst EDGE", A_EDGE, 32'h0);
        rd_chk("rst IRQ_EN", A_IEN, 32'h0);
        tick(1);
        chk("idle rvalid", {31'b0, rvalid}, 32'd0);
        chk("idle rdata", rdata, 32'd0);

        // 3-cycle glitch on key 1 is rejected
        key_n[1] = 1'b0; tick(3); key_n[1] = 1'b1; tick(8);
        rd_chk("glitch STATE", A_STATE, 32'h0);
        rd_chk("glitch EDGE", A_EDGE, 32'h0);

        // key 0 press: stable updates on the 6th edge
        key_n[0] = 1'b0; tick(5);
        rd_chk("k0 STATE e6 pre", A_STATE, 32'h0);
        rd_chk("k0 STATE", A_STATE, 32'h1);
        rd_chk("k0 EDGE", A_EDGE, 32'h1);
        rd_chk("k0 EDGE noclr", A_EDGE, 32'h1);
        key_n[0] = 1'b1; tick(8);
        rd_chk("k0 rel STATE", A_STATE, 32'h0);
        rd_chk("k0 rel EDGE", A_EDGE, 32'h1);

        // key 1 press -> EDGE=3, then W1C
        key_n[1] = 1'b0; tick(8); key_n[1] = 1'b1; tick(8);
        rd_chk("k1 EDGE", A_EDGE, 32'h3);
        wr_chk("w1c b0", A_EDGE, 32'h1, 4'hF);
        rd_chk("w1c EDGE", A_EDGE, 32'h2);
        wr_chk("w1c be0", A_EDGE, 32'h2, 4'h0);
        rd_chk("be0 EDGE", A_EDGE, 32'h2);
        wr_chk("rsv wr", A_RSV, 32'hFFFF_FFFF, 4'hF);
        rd_chk("rsv rd", A_RSV, 32'h0);
        wr_chk("state wr", A_STATE, 32'hFFFF_FFFF, 4'hF);
        rd_chk("state ro", A_STATE, 32'h0);

        // unselected request: no response, no write
        bus(1'b1, BASE + 32'h18, 32'hF, 4'hF, d, v);
        chk("unsel rvalid", {31'b0, v}, 32'd0);
        rd_chk("unsel IRQ_EN", A_IEN, 32'h0);

        // IRQ_EN upper bits read 0; irq follows one cycle after enable
        wr_chk("ien all", A_IEN, 32'hFFFF_FFFF, 4'hF);
        chk("irq same", {31'b0, irq}, 32'd0);
        tick(1);
        chk("irq rise", {31'b0, irq}, 32'd1);
        rd_chk("ien mask", A_IEN, 32'hF);
        wr_chk("ien off", A_IEN, 32'h0, 4'h1);
        chk("irq hold", {31'b0, irq}, 32'd1);
        tick(1);
        chk("irq fall", {31'b0, irq}, 32'd0);
        wr_chk("w1c all", A_EDGE, 32'hF, 4'h1);
        rd_chk("edge clr", A_EDGE, 32'h0);

        // key 2 interrupt path
        wr_chk("ien k2", A_IEN, 32'h4, 4'hF);
        key_n[2] = 1'b0; tick(5);
        chk("k2 irq e5", {31'b0, irq}, 32'd0);
        tick(1);
        chk("k2 irq e6", {31'b0, irq}, 32'd0);
        tick(1);
        chk("k2 irq e7", {31'b0, irq}, 32'd1);
        key_n[2] = 1'b1;
        wr_chk("k2 w1c", A_EDGE, 32'h4, 4'hF);
        chk("k2 irq w1c", {31'b0, irq}, 32'd1);
        tick(1);
        chk("k2 irq low", {31'b0, irq}, 32'd0);
        tick(8);

        // press and W1C on the same edge: press wins
        key_n[0] = 1'b0; tick(5);
        wr_chk("race w1c", A_EDGE, 32'h1, 4'hF);
        rd_chk("race EDGE", A_EDGE, 32'h1);
        key_n[0] = 1'b1; tick(8);
        wr_chk("race clr", A_EDGE, 32'h1, 4'hF);
        rd_chk("race cleared", A_EDGE, 32'h0);

        // back-to-back reads
        req = 1'b1; we = 1'b0; be = 4'hF; addr = A_IEN;
        tick(1);
        chk("b2b rv0", {31'b0, rvalid}, 32'd1);
        chk("b2b rd0", rdata, 32'h4);
        addr = A_STATE;
        tick(1);
        chk("b2b rv1", {31'b0, rvalid}, 32'd1);
        chk("b2b rd1", rdata, 32'h0);
        req = 1'b0;
        tick(1);
        chk("b2b rv end", {31'b0, rvalid}, 32'd0);
        chk("b2b rd end", rdata, 32'h0);

        // reset mid-debounce and mid-access
        key_n[3] = 1'b0; tick(4);
        req = 1'b1; addr = A_IEN;
        #2 arst_n = 1'b0;
        #1;
        chk("mrst rvalid", {31'b0, rvalid}, 32'd0);
        chk("mrst rdata", rdata, 32'h0);
        chk("mrst irq", {31'b0, irq}, 32'd0);
        req = 1'b0;
        #10 arst_n = 1'b1;
        tick(1);
        chk("mrst no rv", {31'b0, rvalid}, 32'd0);
        tick(4);
        rd_chk("k3 EDGE e6 pre", A_EDGE, 32'h0);
        rd_chk("k3 EDGE", A_EDGE, 32'h8);
        rd_chk("k3 STATE", A_STATE, 32'h8);
        rd_chk("mrst IRQ_EN", A_IEN, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
